// File: rtl/deg_to_steps_multi.sv
// -----------------------------------------------------------------------------
// deg_to_steps_multi
//
// Converts a vector of signed joint-angle deltas (fixed-point degrees) into
// per-channel stepper step magnitudes and direction bits. A single shared
// multiplier handles the channels one per cycle. Each channel keeps a
// fractional-step residual so that repeated small moves do not drift.
//
// Arithmetic per channel (all in units of 2^-(2*FRAC_W) steps):
//   prod  = dth * K                       (signed, 2*FRAC_W fractional bits)
//   total = (prod << ustep) + residual    (residual treated as 0 when clr)
//   s     = floor((total + 0.5) / 1)      round to nearest, ties toward +inf
//   res   = total - s                     always in [-0.5, 0.5)
//   dir   = s < 0,  steps = |s|, clipped to 2^STEP_W-1 (sat), res = 0 on clip
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   in_valid   command valid
//   in_ready   command accepted when high (IDLE only)
//   in_dth     NUM_CH signed angle deltas, channel i at [i*ANGLE_W +: ANGLE_W]
//   in_ustep   microstep multiplier: 0=x1, 1=x2, 2=x4, 3=x8
//   in_clr     treat residuals as zero for this command
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   out_steps  step magnitude per channel, channel i at [i*STEP_W +: STEP_W]
//   out_dir    per-channel direction, 1 = negative rotation
//   out_sat    per-channel flag, magnitude clipped to 2^STEP_W-1
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module deg_to_steps_multi #(
  parameter int NUM_CH          = 2,
  parameter int ANGLE_W         = 32,
  parameter int FRAC_W          = 16,
  parameter int STEP_W          = 32,
  parameter int K_STEPS_PER_DEG = 36409
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH*ANGLE_W-1:0]  in_dth,
  input  logic [1:0]                 in_ustep,
  input  logic                       in_clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_CH*STEP_W-1:0]   out_steps,
  output logic [NUM_CH-1:0]          out_dir,
  output logic [NUM_CH-1:0]          out_sat
);

  // K is an unsigned Q16.16 constant held in a 32-bit field.
  localparam int K_W    = 32;
  // Signed product of a signed angle and a zero-extended K.
  localparam int PROD_W = ANGLE_W + K_W + 1;
  // Headroom for the x8 microstep shift plus the residual add and rounding.
  localparam int TOT_W  = PROD_W + 4;
  // Residual: signed, 2*FRAC_W fractional bits, magnitude below one half.
  localparam int RES_W  = 2 * FRAC_W + 1;
  // Integer part of the rounded total.
  localparam int S_W    = TOT_W - 2 * FRAC_W;
  localparam int CMP_W  = (S_W > STEP_W) ? S_W : STEP_W + 1;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [IDX_W-1:0]  LAST_CH  = IDX_W'(NUM_CH - 1);
  localparam logic [K_W-1:0]    K_VEC    = K_W'(K_STEPS_PER_DEG);
  localparam logic [TOT_W-1:0]  HALF_TOT = {{(TOT_W - 2 * FRAC_W){1'b0}}, 1'b1,
                                            {(2 * FRAC_W - 1){1'b0}}};
  localparam logic [RES_W-1:0]  HALF_RES = {1'b0, 1'b1, {(2 * FRAC_W - 1){1'b0}}};
  localparam logic [STEP_W-1:0] STEP_MAX = {STEP_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Latched command and serial channel index.
  logic [NUM_CH*ANGLE_W-1:0] dth_q;
  logic [1:0]                ustep_q;
  logic                      clr_q;
  logic [IDX_W-1:0]          ch_q;

  // Per-channel state and results.
  logic [RES_W-1:0]  res_q   [NUM_CH];
  logic [STEP_W-1:0] steps_q [NUM_CH];
  logic [NUM_CH-1:0] dir_q;
  logic [NUM_CH-1:0] sat_q;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: registers are updated with non-blocking assignments so every
      // always_ff samples the pre-edge value of every other register.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_CALC;
      end
      S_CALC: begin
        if (ch_q == LAST_CH) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared datapath for the channel selected by ch_q
  // ---------------------------------------------------------------------------
  logic [ANGLE_W-1:0]       dth_sel;
  logic signed [PROD_W-1:0] dth_ext;
  logic signed [PROD_W-1:0] k_ext;
  logic signed [PROD_W-1:0] prod;
  logic [TOT_W-1:0]         shifted;
  logic [RES_W-1:0]         res_sel;
  logic [TOT_W-1:0]         total;
  logic [TOT_W-1:0]         rounded;
  logic [S_W-1:0]           s_int;
  logic                     s_neg;
  logic [S_W-1:0]           mag;
  logic                     mag_sat;
  logic [RES_W-1:0]         res_new;

  always_comb begin
    dth_sel = dth_q[int'(ch_q)*ANGLE_W +: ANGLE_W];
    dth_ext = {{(PROD_W - ANGLE_W){dth_sel[ANGLE_W-1]}}, dth_sel};
    k_ext   = {{(PROD_W - K_W){1'b0}}, K_VEC};
    prod    = dth_ext * k_ext;

    // Sign-extend before shifting so the microstep gain keeps the sign.
    shifted = {{(TOT_W - PROD_W){prod[PROD_W-1]}}, prod} << ustep_q;
    res_sel = clr_q ? '0 : res_q[ch_q];
    total   = shifted + {{(TOT_W - RES_W){res_sel[RES_W-1]}}, res_sel};

    // Adding one half and truncating the fraction gives round-to-nearest with
    // ties toward +inf; the dropped fraction minus one half is the residual.
    rounded = total + HALF_TOT;
    s_int   = rounded[TOT_W-1 -: S_W];
    res_new = {1'b0, rounded[2*FRAC_W-1:0]} - HALF_RES;

    s_neg   = s_int[S_W-1];
    mag     = s_neg ? (~s_int + S_W'(1)) : s_int;
    mag_sat = CMP_W'(mag) > CMP_W'(STEP_MAX);
  end

  // ---------------------------------------------------------------------------
  // Command latch, channel sequencing, residual and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dth_q   <= '0;
      ustep_q <= '0;
      clr_q   <= 1'b0;
      ch_q    <= '0;
      dir_q   <= '0;
      sat_q   <= '0;
      // NOTE: the residual array is reset explicitly because the conversion
      // result depends on it; result registers are reset so outputs read 0.
      for (int i = 0; i < NUM_CH; i++) begin
        res_q[i]   <= '0;
        steps_q[i] <= '0;
      end
    end else begin
      if (state_q == S_IDLE && in_valid) begin
        dth_q   <= in_dth;
        ustep_q <= in_ustep;
        clr_q   <= in_clr;
        ch_q    <= '0;
      end
      if (state_q == S_CALC) begin
        steps_q[ch_q] <= mag_sat ? STEP_MAX : STEP_W'(mag);
        dir_q[ch_q]   <= s_neg;
        sat_q[ch_q]   <= mag_sat;
        // A clipped move loses its fraction; start the next move clean.
        res_q[ch_q]   <= mag_sat ? '0 : res_new;
        ch_q          <= ch_q + IDX_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign out_steps[g*STEP_W +: STEP_W] = steps_q[g];
  end

  assign out_dir = dir_q;
  assign out_sat = sat_q;

endmodule
